avalon_st_arbiter: RTL and testbench
====================================

# avalon_st_arbiter

Round-robin arbiter that shares one Avalon-ST sink (8-bit data, valid/ready, ready latency 0) between N streaming sources. One source at a time is granted, for a bounded burst. Its beats pass through a single registered output stage to the sink. The block sits between the byte-stream generators and the common downstream consumer.

## Interface
- `N`, default 4: number of sources, 2..8.
- `DATA_W`, default 8: beat width in bits.
- `MAX_BURST`, default 4: maximum number of beats accepted per grant, at least 1.

- `clk`, input, 1: rising-edge clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `src_valid`, input, N: per-source valid; bit i belongs to source i.
- `src_data`, input, N*DATA_W: per-source data; source i is bits [i*DATA_W +: DATA_W].
- `src_ready`, output, N: per-source ready; at most one bit is high at any time.
- `snk_valid`, output, 1: registered; sink data is valid.
- `snk_data`, output, DATA_W: registered sink data.
- `snk_ready`, input, 1: sink can accept a beat this cycle.
- `grant`, output, N: registered one-hot current owner; all zero when idle.
- `busy`, output, 1: high whenever `grant` is non-zero or `snk_valid` is high.

## Operation
- **Reset values:** `snk_valid`=0, `snk_data`=0, `grant`=0, `busy`=0, `src_ready`=0, beat counter=0, state=IDLE. The priority pointer is set so that source 0 has highest priority at the first arbitration.
- **IDLE state:**
  - If any `src_valid` bit is high, the winner is the first requesting index found by searching upward (with wrap) from pointer+1.
  - The winner is loaded into `grant`, the counter is cleared, and the state moves to GRANT.
  - With no request, the state stays IDLE.
- **GRANT state (owner g):**
  - `src_ready[g]` = !`snk_valid` || `snk_ready`. All other `src_ready` bits are 0.
  - A source transfer occurs when `src_valid[g]` && `src_ready[g]`. It loads `snk_data` with src_data[g], sets `snk_valid`=1, and increments the counter.
  - **Release on burst limit:** if a transfer occurs and counter+1 == `MAX_BURST`, the grant is released.
  - **Release on dropped valid:** if `src_valid[g]`=0, the grant is released that cycle, including the first GRANT cycle.
  - **On release:** `grant` goes to 0, the pointer is set to g, and the state returns to IDLE.
- **Output register:**
  - If `snk_valid` && `snk_ready` with no new load, `snk_valid` clears.
  - A load and a sink transfer in the same cycle keep `snk_valid`=1 with the new data.
  - `snk_data` holds its value while `snk_valid` && !`snk_ready`.
- **Register drain:** the output register drains independently of arbitration. A beat from the previous owner may still be held while the next grant is issued.
- **No loss or duplication:** a beat is never dropped or duplicated.

## Timing
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge k is granted from k+1, and `src_ready` can rise in cycle k+1.
- **Source-to-sink latency:** 1 cycle. A source beat accepted at edge k appears on `snk_valid`/`snk_data` after edge k.
- **Throughput:** with `snk_ready`=1 held, 1 beat per cycle within a burst. There is exactly 1 IDLE cycle between consecutive grants.
- **Combinational paths:** `src_ready` is combinational from `snk_ready`, `snk_valid` and `grant`. No path exists from `src_valid` to `src_ready`.
- **Fairness:** a source requesting continuously waits at most (N-1) grants before being served.
- **Reset mid-operation:** asserting `resetn`=0 immediately forces all outputs to their reset values. A beat held in the output register is discarded.

## Test plan
- **Single source:** source 1 presents 0x04, 0x05, 0x06, 0x07 with sink always ready. `grant`=0b0010 from the cycle after the request, and the sink receives 0x04..0x07 one per cycle with 1-cycle latency. Release happens after the 4th beat, then `grant`=0.
- **Two sources contending:** sources 0 and 2 each have 8 beats (0xA0.., 0xC0..), `MAX_BURST`=4. The sink receives A0-A3, C0-C3, A4-A7, C4-C7, with a 1-cycle gap at each grant change.
- **Four sources from reset:** all request simultaneously after reset. Grant order is 0, 1, 2, 3, 0.
- **Sink backpressure:** `snk_ready`=0 for 3 cycles while `snk_valid`=1 with data 0x05. `snk_data` stays 0x05 and `src_ready[g]`=0 for those cycles. On resume, no beat is lost or duplicated.
- **Dropped valid:** the owner drops `src_valid` after 2 beats. The grant is released that cycle, and a waiting source 3 is granted 1 cycle later. The pointer advances past the old owner.
- **Reset mid-burst:** `resetn` is pulsed low while `snk_valid`=1. `snk_valid`, `grant`, `src_ready` and `busy` drop to 0 immediately. After release, source 0 wins the first arbitration.

Source files
------------

// File: rtl/avalon_st_arbiter.sv
// Round-robin arbiter sharing one Avalon-ST sink between N sources.
// Each grant carries a bounded burst into a single registered output stage.
module avalon_st_arbiter #(
    parameter int N         = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          src_valid,
    input  logic [N*DATA_W-1:0]   src_data,
    output logic [N-1:0]          src_ready,
    output logic                  snk_valid,
    output logic [DATA_W-1:0]     snk_data,
    input  logic                  snk_ready,
    output logic [N-1:0]          grant,
    output logic                  busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic               any_req;
    logic [N-1:0]       winner_oh;
    logic [DATA_W-1:0]  sel_data;
    logic               out_free;
    logic               xfer;
    logic               last_beat;

    // Search downward over offsets so the smallest offset from ptr+1 is the last, winning, write.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        winner    = '0;
        any_req   = 1'b0;
        idx       = '0;
        winner_oh = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (src_valid[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
        winner_oh[winner] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready depends only on registered state and snk_ready, never on src_valid.
    assign out_free  = !snk_valid || snk_ready;
    assign src_ready = grant & {N{out_free}};
    assign xfer      = (state == GRANT) && src_valid[owner] && out_free;
    assign last_beat = (cnt == CNT_W'(MAX_BURST - 1));
    assign busy      = (|grant) || snk_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= IDX_W'(N - 1);
            owner     <= '0;
            cnt       <= '0;
            snk_valid <= 1'b0;
            snk_data  <= '0;
        end else begin
            // Output stage drains independently of the arbitration state.
            if (xfer) begin
                snk_valid <= 1'b1;
                snk_data  <= sel_data;
            end else if (snk_ready) begin
                snk_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= winner_oh;
                        owner <= winner;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!src_valid[owner] || (xfer && last_beat)) begin
                        grant <= '0;
                        ptr   <= owner;
                        state <= IDLE;
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Scoreboard bench for avalon_st_arbiter: a burst-level round-robin model predicts
// grant order, beat order and (with the sink always ready) exact cycle timing.
module tb_avalon_st_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      src_valid;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_ready;
    logic              snk_valid;
    logic [DW-1:0]     snk_data;
    logic              snk_ready;
    logic [N-1:0]      grant;
    logic              busy;

    avalon_st_arbiter #(.N(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_data  (snk_data),
        .snk_ready (snk_ready),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {int src; int start; int stop;} own_t;
    typedef struct {logic [DW-1:0] data; int cyc;} beat_t;

    own_t          exp_own[$];
    beat_t         exp_beat[$];
    logic [DW-1:0] srcq[N][$];

    int       checks = 0;
    int       passes = 0;
    int       cyc = 0;
    int       model_ptr = N - 1;
    bit       timed = 0;
    int       ready_mode = 0;
    int       hold_left = 0;
    bit       drv_en = 0;
    bit       mon_reset = 0;
    logic [N-1:0] fire;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Burst-level model: round robin from last owner + 1, each grant takes up to MB beats.
    // A full burst releases on its last transfer edge; a short one releases one edge later
    // when valid is seen low. Grants start one edge after the previous release.
    task automatic build_expected(input int k0);
        int    s, w, b, c;
        int    left[N];
        int    pos[N];
        bit    more;
        beat_t eb;
        own_t  eo;
        s = k0;
        for (int i = 0; i < N; i++) begin
            left[i] = srcq[i].size();
            pos[i]  = 0;
        end
        more = 1'b1;
        while (more) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_ptr + k) % N;
                if (w < 0 && left[c] > 0) w = c;
            end
            if (w < 0) begin
                more = 1'b0;
            end else begin
                b = (left[w] < MB) ? left[w] : MB;
                for (int i = 0; i < b; i++) begin
                    eb.data = srcq[w][pos[w] + i];
                    eb.cyc  = s + 1 + i;
                    exp_beat.push_back(eb);
                end
                eo.src   = w;
                eo.start = s;
                eo.stop  = (b == MB) ? s + b : s + b + 1;
                exp_own.push_back(eo);
                pos[w]   += b;
                left[w]  -= b;
                model_ptr = w;
                s = eo.stop + 1;
            end
        end
    endtask

    // Source/sink driver: updates inputs at negedge, records which sources will fire.
    initial begin
        fire = '0;
        forever begin
            @(negedge clk);
            if (drv_en) begin
                for (int i = 0; i < N; i++) begin
                    if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                end
                for (int i = 0; i < N; i++) begin
                    src_valid[i] = (srcq[i].size() > 0);
                    src_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
                end
                case (ready_mode)
                    0: snk_ready = 1'b1;
                    1: snk_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (snk_valid && hold_left > 0) begin
                            snk_ready = 1'b0;
                            hold_left--;
                        end else begin
                            snk_ready = 1'b1;
                        end
                    end
                endcase
                #1;
                fire = src_valid & src_ready;
            end else begin
                fire = '0;
            end
        end
    end

    // Monitor: samples between edges and pops the scoreboard on every sink transfer.
    initial begin
        own_t         cur;
        beat_t        eb;
        bit           have_cur;
        bit           prev_hold;
        logic [DW-1:0] prev_data;
        logic [N-1:0] prev_grant;
        have_cur   = 1'b0;
        prev_hold  = 1'b0;
        prev_data  = '0;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn || mon_reset) begin
                have_cur   = 1'b0;
                prev_hold  = 1'b0;
                prev_grant = '0;
            end else begin
                check("ready_within_grant", 64'((src_ready & ~grant) == '0 && $onehot0(src_ready)), 64'd1);
                check("busy", 64'(busy), 64'((|grant) || snk_valid));
                if (snk_valid && !snk_ready) check("stall_src_ready", 64'(src_ready), 64'd0);
                if (prev_hold) begin
                    check("hold_valid", 64'(snk_valid), 64'd1);
                    check("hold_data", 64'(snk_data), 64'(prev_data));
                end
                prev_hold = snk_valid && !snk_ready;
                prev_data = snk_data;

                if (grant != '0 && prev_grant == '0) begin
                    if (exp_own.size() == 0) begin
                        fail_now("unexpected_grant");
                        have_cur = 1'b0;
                    end else begin
                        cur = exp_own.pop_front();
                        have_cur = 1'b1;
                        check("grant_owner", 64'(grant), 64'd1 << cur.src);
                        if (timed) check("grant_start_cycle", 64'(cyc), 64'(cur.start));
                    end
                end else if (grant != '0) begin
                    check("grant_stable", 64'(grant), 64'(prev_grant));
                end else if (prev_grant != '0 && have_cur && timed) begin
                    check("release_cycle", 64'(cyc), 64'(cur.stop));
                end
                prev_grant = grant;

                if (snk_valid && snk_ready) begin
                    if (exp_beat.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        eb = exp_beat.pop_front();
                        check("sink_data", 64'(snk_data), 64'(eb.data));
                        if (timed) check("sink_cycle", 64'(cyc), 64'(eb.cyc));
                    end
                end
            end
        end
    end

    function automatic bit queues_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_test(input int mode);
        int n;
        timed      = (mode == 0);
        ready_mode = mode;
        hold_left  = 3;
        @(posedge clk);
        #1;
        build_expected(cyc + 1);
        drv_en = 1'b1;
        n = 0;
        while (!(exp_beat.size() == 0 && queues_empty() && grant == '0 && !snk_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        check("owners_left", 64'(exp_own.size()), 64'd0);
    endtask

    task automatic do_reset();
        drv_en = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        model_ptr = N - 1;
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        src_valid = '0;
        src_data  = '0;
        snk_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_snk_valid", 64'(snk_valid), 64'd0);
        check("rst_snk_data", 64'(snk_data), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single source 1, four beats, sink always ready.
        for (int j = 0; j < 4; j++) srcq[1].push_back(8'(4 + j));
        run_test(0);

        // Reset while the output register holds a beat.
        for (int j = 0; j < 8; j++) srcq[0].push_back(8'(8'h10 + j));
        timed      = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        build_expected(cyc + 1);
        drv_en = 1'b1;
        n = 0;
        while (!snk_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("wait_snk_valid_timeout");
        check("pre_reset_snk_valid", 64'(snk_valid), 64'd1);
        #3;
        drv_en    = 1'b0;
        mon_reset = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        src_valid = '0;
        resetn    = 1'b0;
        #1;
        check("midrst_snk_valid", 64'(snk_valid), 64'd0);
        check("midrst_snk_data", 64'(snk_data), 64'd0);
        check("midrst_grant", 64'(grant), 64'd0);
        check("midrst_src_ready", 64'(src_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        exp_beat.delete();
        exp_own.delete();
        repeat (2) @(negedge clk);
        mon_reset = 1'b0;
        resetn    = 1'b1;
        model_ptr = N - 1;

        // Sources 0 and 2 contend with 8 beats each; source 0 must win first after reset.
        for (int j = 0; j < 8; j++) begin
            srcq[0].push_back(8'(8'hA0 + j));
            srcq[2].push_back(8'(8'hC0 + j));
        end
        run_test(0);

        // All four sources request together from reset.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 5; j++) srcq[i].push_back(8'((i << 4) | j));
        run_test(0);

        // Owner (source 1) drops valid after 2 beats while source 3 waits.
        srcq[1].push_back(8'h51);
        srcq[1].push_back(8'h52);
        for (int j = 0; j < 3; j++) srcq[3].push_back(8'(8'h70 + j));
        run_test(0);

        // Sink backpressure for 3 cycles on the first beat 0x05.
        for (int j = 0; j < 3; j++) srcq[2].push_back(8'(5 + j));
        run_test(2);

        // Randomized rounds with random backpressure.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 6);
                for (int j = 0; j < cnt; j++) srcq[i].push_back(8'($urandom_range(0, 255)));
            end
            run_test(1);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
